bnn_seq_classifier: RTL and testbench

BNN_SEQ_CLASSIFIER -- requirements
Module: bnn_seq_classifier

---
 rtl/bnn_seq_classifier.sv | 154 +++++++++++++++
 tb/tb_bnn_seq_classifier.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_seq_classifier.sv
`default_nettype none
// ============================================================================
// Module      : bnn_seq_classifier
// Description : Sequential binary-neural-network classifier. Streams a binary
//               image in BEAT_W-bit beats, then scores one class per cycle as
//               popcount(XNOR(image, row_c)) and reports the arg-max class
//               (ties resolve to the lower index).
// Options     : define BNN_SCORE_OUT_EN to expose the winning score on
//               out_score.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_seq_classifier #(
    parameter int IMG_SIZE  = 30,
    parameter int BEAT_W    = 30,
    parameter int NUM_CLASS = 10,
    localparam int IMG_BITS = IMG_SIZE * IMG_SIZE,
    localparam int CLS_W    = $clog2(NUM_CLASS),
    localparam int SCORE_W  = $clog2(IMG_BITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BEAT_W-1:0]             in_data,
    input  logic [NUM_CLASS*IMG_BITS-1:0] weights,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CLS_W-1:0]              out_class,
    output logic                          busy
`ifdef BNN_SCORE_OUT_EN
    ,
    output logic [SCORE_W-1:0]            out_score
`endif
);

    localparam int NBEATS = IMG_BITS / BEAT_W;
    localparam int K_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [K_W-1:0]       beat_q, beat_d;
    logic [CLS_W-1:0]     cls_q, cls_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [CLS_W-1:0]     best_class_q, best_class_d;
    logic [IMG_BITS-1:0]  image_q;

    logic                 w_accept;
    logic [IMG_BITS-1:0]  w_row;
    logic [IMG_BITS-1:0]  w_match;
    logic [SCORE_W-1:0]   w_score;

    assign w_accept = in_valid && (state_q == LOAD);

    // Select the weight row of the class under evaluation this cycle.
    always_comb begin
        w_row = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            if (cls_q == CLS_W'(c)) begin
                w_row = weights[c*IMG_BITS +: IMG_BITS];
            end
        end
    end

    // XNOR-popcount score of the stored image against the selected row.
    always_comb begin
        w_match = ~(image_q ^ w_row);
        w_score = '0;
        for (int i = 0; i < IMG_BITS; i++) begin
            w_score = w_score + SCORE_W'(w_match[i]);
        end
    end

    // Next-state, counter and running-best logic.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        cls_d        = cls_q;
        best_score_d = best_score_q;
        best_class_d = best_class_q;
        case (state_q)
            LOAD: begin
                if (w_accept) begin
                    if (beat_q == K_W'(NBEATS - 1)) begin
                        beat_d  = '0;
                        cls_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                // Class 0 seeds the best; later classes need a strict win.
                if ((cls_q == '0) || (w_score > best_score_q)) begin
                    best_score_d = w_score;
                    best_class_d = cls_q;
                end
                if (cls_q == CLS_W'(NUM_CLASS - 1)) begin
                    cls_d   = '0;
                    state_d = DONE;
                end else begin
                    cls_d = cls_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Control and result registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            beat_q       <= '0;
            cls_q        <= '0;
            best_score_q <= '0;
            best_class_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            cls_q        <= cls_d;
            best_score_q <= best_score_d;
            best_class_q <= best_class_d;
        end
    end

    // Image store; contents are don't-care until fully reloaded.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            image_q[int'(beat_q)*BEAT_W +: BEAT_W] <= in_data;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != LOAD);
    assign out_class = best_class_q;
`ifdef BNN_SCORE_OUT_EN
    assign out_score = best_score_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bnn_seq_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_seq_classifier
// Description : Scoreboard bench for bnn_seq_classifier. The driver pushes the
//               expected class/score/latency for each full image; a monitor
//               pops and compares when out_valid rises and checks the DONE
//               hold-off and release behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_seq_classifier;

    localparam int IMG_SIZE  = 30;
    localparam int BEAT_W    = 30;
    localparam int NUM_CLASS = 10;
    localparam int IMG_BITS  = IMG_SIZE * IMG_SIZE;
    localparam int NBEATS    = IMG_BITS / BEAT_W;
    localparam int CLS_W     = $clog2(NUM_CLASS);
    localparam int SCORE_W   = $clog2(IMG_BITS + 1);

    typedef struct {
        int cls;
        int score;
        int cyc;
        int hold;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [BEAT_W-1:0]             in_data = '0;
    logic [NUM_CLASS*IMG_BITS-1:0] weights = '0;
    logic                          out_valid;
    logic                          out_ready = 1'b1;
    logic [CLS_W-1:0]              out_class;
    logic                          busy;
`ifdef BNN_SCORE_OUT_EN
    logic [SCORE_W-1:0]            out_score;
`endif

    logic [NUM_CLASS*IMG_BITS-1:0] wts_stage = '0;
    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    bnn_seq_classifier #(
        .IMG_SIZE (IMG_SIZE),
        .BEAT_W   (BEAT_W),
        .NUM_CLASS(NUM_CLASS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .weights  (weights),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .busy     (busy)
`ifdef BNN_SCORE_OUT_EN
        ,
        .out_score(out_score)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [IMG_BITS-1:0] low_ones(input int k);
        logic [IMG_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < k; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [IMG_BITS-1:0] rand_row();
        logic [IMG_BITS-1:0] r;
        for (int i = 0; i < IMG_BITS; i++) r[i] = 1'($urandom & 1);
        return r;
    endfunction

    task automatic set_row(input int c, input logic [IMG_BITS-1:0] row);
        wts_stage[c*IMG_BITS +: IMG_BITS] = row;
    endtask

    task automatic set_all(input logic [IMG_BITS-1:0] row);
        for (int c = 0; c < NUM_CLASS; c++) set_row(c, row);
    endtask

    // Drive nb beats of img, starting at a falling edge; a full image with
    // want=1 registers its expected result before the last beat is taken.
    task automatic send_image(input logic [IMG_BITS-1:0] img, input int nb,
                              input bit gaps, input bit want, input int ecls,
                              input int escore, input int hold);
        int n;
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            n = 0;
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (b == 0) weights = wts_stage;
            in_valid = 1'b1;
            in_data  = img[b*BEAT_W +: BEAT_W];
            if (b == NBEATS - 1 && want) begin
                e.cls = ecls; e.score = escore; e.hold = hold;
                e.cyc = cyc + 1 + NUM_CLASS;
                sb.push_back(e);
            end
            @(negedge clk);
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = BEAT_W'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (nb == NBEATS) begin
            chk("busy_in_compute", int'(busy), 1);
            chk("in_ready_in_compute", int'(in_ready), 0);
        end
    endtask

    // Asynchronous reset pulse placed mid-cycle.
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_class", int'(out_class), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare results, check DONE hold-off and release.
    bit   prev_valid = 1'b0;
    bit   hs_pend    = 1'b0;
    int   hold_cnt   = 0;
    int   cap_class  = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            hs_pend    = 1'b0;
            hold_cnt   = 0;
            out_ready  = 1'b1;
        end else begin
            if (hs_pend) begin
                chk("valid_drop_after_hs", int'(out_valid), 0);
                chk("ready_after_hs", int'(in_ready), 1);
                chk("busy_after_hs", int'(busy), 0);
                hs_pend = 1'b0;
            end
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                    hold_cnt = 0;
                end else begin
                    cur = sb.pop_front();
                    chk("out_class", int'(out_class), cur.cls);
                    chk("latency_cycle", cyc, cur.cyc);
`ifdef BNN_SCORE_OUT_EN
                    chk("out_score", int'(out_score), cur.score);
`endif
                    hold_cnt = cur.hold;
                end
                cap_class = int'(out_class);
            end else if (out_valid) begin
                chk("class_stable", int'(out_class), cap_class);
                chk("ready_low_in_done", int'(in_ready), 0);
                chk("busy_in_done", int'(busy), 1);
            end
            if (out_valid) begin
                if (hold_cnt > 0) begin
                    out_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    out_ready = 1'b1;
                    hs_pend   = 1'b1;
                end
            end else begin
                out_ready = 1'b1;
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        logic [IMG_BITS-1:0] img0, img1, imgh;
        int ones_cnt[NUM_CLASS];
        int n;
        img0 = '0;
        img1 = '1;
        imgh = low_ones(450);
        ones_cnt = '{500, 400, 300, 200, 100, 150, 100, 250, 900, 700};

        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_out_class", int'(out_class), 0);
        @(negedge clk);
        rst = 1'b0;

        // Row 3 matches a blank image exactly; result held off 5 cycles.
        set_all(img1); set_row(3, img0);
        send_image(img0, NBEATS, 1'b0, 1'b1, 3, 900, 5);

        // Identical rows: every class scores 600, lowest index wins.
        set_all(low_ones(300));
        send_image(img0, NBEATS, 1'b0, 1'b1, 0, 600, 0);

        // Half image; row 7 equal, row 2 inverse, rest random; with gaps.
        for (int c = 0; c < NUM_CLASS; c++) set_row(c, rand_row());
        set_row(7, imgh); set_row(2, ~imgh);
        send_image(imgh, NBEATS, 1'b1, 1'b1, 7, 900, 0);

        // Scores 400,500,600,700,800,750,800,650,0,200: tie 4/6 keeps 4.
        for (int c = 0; c < NUM_CLASS; c++) set_row(c, low_ones(ones_cnt[c]));
        send_image(img0, NBEATS, 1'b0, 1'b1, 4, 800, 2);

        // All scores zero: class 0 must reseed the best.
        set_all(img0);
        send_image(img1, NBEATS, 1'b0, 1'b1, 0, 0, 0);

        // Last class is the unique winner.
        set_row(9, img1);
        send_image(img1, NBEATS, 1'b0, 1'b1, 9, 900, 1);

        // Reset after 10 beats, then a fresh image with and without gaps.
        set_all(rand_row());
        send_image(rand_row(), 10, 1'b0, 1'b0, 0, 0, 0);
        pulse_reset();
        set_all(img1); set_row(5, img0);
        send_image(img0, NBEATS, 1'b1, 1'b1, 5, 900, 0);
        send_image(img0, NBEATS, 1'b0, 1'b1, 5, 900, 0);

        // Reset in the middle of COMPUTE discards the result.
        send_image(img1, NBEATS, 1'b0, 1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);
        pulse_reset();
        for (int c = 0; c < NUM_CLASS; c++) set_row(c, rand_row());
        set_row(7, imgh); set_row(2, ~imgh);
        send_image(imgh, NBEATS, 1'b0, 1'b1, 7, 900, 0);

        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
